// File: rtl/fxu_reservation_station.sv
// Reservation station for the fixed-point unit. It holds dispatched instructions
// until both operands are present, snoops the result bus for missing operands,
// and feeds the oldest-by-index ready entry into a single issue register.
module fxu_reservation_station #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_instr_valid,
  input  logic [3:0]                 in_rob_idx,
  input  logic [3:0]                 in_opcode,
  input  logic [7:0]                 in_i,
  input  logic                       in_a_valid,
  input  logic [15:0]                in_a_value,
  input  logic [3:0]                 in_a_owner,
  input  logic                       in_b_valid,
  input  logic [15:0]                in_b_value,
  input  logic [3:0]                 in_b_owner,
  output logic                       full,
  input  logic                       cdb_valid,
  input  logic [3:0]                 cdb_rob_idx,
  input  logic [15:0]                cdb_value,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [3:0]                 out_rob_idx,
  output logic [3:0]                 out_opcode,
  output logic [15:0]                out_a,
  output logic [15:0]                out_b,
  output logic [7:0]                 out_i,
  input  logic                       alu_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  // Entry state: busy is the only reset bit; everything else is qualified by it.
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] a_valid_q, a_valid_d;
  logic [DEPTH-1:0] b_valid_q, b_valid_d;
  logic [3:0]       rob_q     [DEPTH];
  logic [3:0]       rob_d     [DEPTH];
  logic [3:0]       opc_q     [DEPTH];
  logic [3:0]       opc_d     [DEPTH];
  logic [7:0]       imm_q     [DEPTH];
  logic [7:0]       imm_d     [DEPTH];
  logic [15:0]      a_value_q [DEPTH];
  logic [15:0]      a_value_d [DEPTH];
  logic [3:0]       a_owner_q [DEPTH];
  logic [3:0]       a_owner_d [DEPTH];
  logic [15:0]      b_value_q [DEPTH];
  logic [15:0]      b_value_d [DEPTH];
  logic [3:0]       b_owner_q [DEPTH];
  logic [3:0]       b_owner_d [DEPTH];

  // Issue register.
  logic        out_valid_q, out_valid_d;
  logic [3:0]  out_rob_q, out_rob_d;
  logic [3:0]  out_opc_q, out_opc_d;
  logic [15:0] out_a_q, out_a_d;
  logic [15:0] out_b_q, out_b_d;
  logic [7:0]  out_i_q, out_i_d;

  logic [DEPTH-1:0] ready;
  logic             any_ready;
  logic [IW-1:0]    sel_idx;
  logic [IW-1:0]    free_idx;
  logic [CW-1:0]    occ;
  logic             issue_fire;
  logic             disp_fire;
  logic             a_byp;
  logic             b_byp;

  // Readiness, lowest-index pick for issue and for allocation, and occupancy,
  // all from registered state so a same-cycle free or wakeup is not visible.
  always_comb begin
    ready     = busy_q & a_valid_q & b_valid_q;
    any_ready = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    occ       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        any_ready = 1'b1;
        sel_idx   = IW'(i);
      end
      if (!busy_q[i]) begin
        free_idx = IW'(i);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + CW'(busy_q[i]);
    end
  end

  assign count      = occ;
  assign full       = (occ == CW'(DEPTH));
  assign issue_fire = any_ready & (~out_valid_q | alu_ready) & ~flush;
  assign disp_fire  = in_instr_valid & ~full & ~flush;
  assign a_byp      = ~in_a_valid & cdb_valid & (cdb_rob_idx == in_a_owner);
  assign b_byp      = ~in_b_valid & cdb_valid & (cdb_rob_idx == in_b_owner);

  // Next state: wakeup, then free the issued entry, then allocate; flush wins.
  always_comb begin
    busy_d    = busy_q;
    a_valid_d = a_valid_q;
    b_valid_d = b_valid_q;
    rob_d     = rob_q;
    opc_d     = opc_q;
    imm_d     = imm_q;
    a_value_d = a_value_q;
    a_owner_d = a_owner_q;
    b_value_d = b_value_q;
    b_owner_d = b_owner_q;

    out_valid_d = out_valid_q;
    out_rob_d   = out_rob_q;
    out_opc_d   = out_opc_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_i_d     = out_i_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && cdb_valid) begin
        if (!a_valid_q[i] && (a_owner_q[i] == cdb_rob_idx)) begin
          a_valid_d[i] = 1'b1;
          a_value_d[i] = cdb_value;
        end
        if (!b_valid_q[i] && (b_owner_q[i] == cdb_rob_idx)) begin
          b_valid_d[i] = 1'b1;
          b_value_d[i] = cdb_value;
        end
      end
    end

    if (issue_fire) begin
      busy_d[sel_idx] = 1'b0;
      out_valid_d     = 1'b1;
      out_rob_d       = rob_q[sel_idx];
      out_opc_d       = opc_q[sel_idx];
      out_a_d         = a_value_q[sel_idx];
      out_b_d         = b_value_q[sel_idx];
      out_i_d         = imm_q[sel_idx];
    end else if (alu_ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end

    if (disp_fire) begin
      busy_d[free_idx]    = 1'b1;
      rob_d[free_idx]     = in_rob_idx;
      opc_d[free_idx]     = in_opcode;
      imm_d[free_idx]     = in_i;
      a_owner_d[free_idx] = in_a_owner;
      b_owner_d[free_idx] = in_b_owner;
      a_valid_d[free_idx] = in_a_valid | a_byp;
      b_valid_d[free_idx] = in_b_valid | b_byp;
      a_value_d[free_idx] = a_byp ? cdb_value : in_a_value;
      b_value_d[free_idx] = b_byp ? cdb_value : in_b_value;
    end

    if (flush) begin
      busy_d      = '0;
      out_valid_d = 1'b0;
    end
  end

  // Control state: reset takes priority over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Payload state: never reset, only meaningful while the owning valid/busy is set.
  always_ff @(posedge clk) begin
    a_valid_q <= a_valid_d;
    b_valid_q <= b_valid_d;
    rob_q     <= rob_d;
    opc_q     <= opc_d;
    imm_q     <= imm_d;
    a_value_q <= a_value_d;
    a_owner_q <= a_owner_d;
    b_value_q <= b_value_d;
    b_owner_q <= b_owner_d;
    out_rob_q <= out_rob_d;
    out_opc_q <= out_opc_d;
    out_a_q   <= out_a_d;
    out_b_q   <= out_b_d;
    out_i_q   <= out_i_d;
  end

  assign out_valid   = out_valid_q;
  assign out_rob_idx = out_rob_q;
  assign out_opcode  = out_opc_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_i       = out_i_q;

endmodule

// File: tb/tb_fxu_reservation_station.sv
// Bench for fxu_reservation_station: directed scenarios followed by random
// traffic, checked against an entry-table model and an issue scoreboard.
module tb_fxu_reservation_station;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, in_instr_valid, in_a_valid, in_b_valid, cdb_valid, flush, alu_ready;
  logic [3:0]  in_rob_idx, in_opcode, in_a_owner, in_b_owner, cdb_rob_idx;
  logic [7:0]  in_i;
  logic [15:0] in_a_value, in_b_value, cdb_value;
  logic        full, out_valid;
  logic [3:0]  out_rob_idx, out_opcode;
  logic [15:0] out_a, out_b;
  logic [7:0]  out_i;
  logic [2:0]  count;

  fxu_reservation_station #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_instr_valid(in_instr_valid), .in_rob_idx(in_rob_idx), .in_opcode(in_opcode), .in_i(in_i),
    .in_a_valid(in_a_valid), .in_a_value(in_a_value), .in_a_owner(in_a_owner),
    .in_b_valid(in_b_valid), .in_b_value(in_b_value), .in_b_owner(in_b_owner),
    .full(full), .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_value(cdb_value),
    .flush(flush), .out_valid(out_valid), .out_rob_idx(out_rob_idx), .out_opcode(out_opcode),
    .out_a(out_a), .out_b(out_b), .out_i(out_i), .alu_ready(alu_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          busy;
    logic [3:0]  rob, opc, ao, bo;
    logic [7:0]  imm;
    bit          av, bv;
    logic [15:0] a, b;
  } ent_t;

  typedef struct {
    logic [3:0]  rob, opc;
    logic [15:0] a, b;
    logic [7:0]  imm;
  } iss_t;

  ent_t m_ent[DEPTH];
  bit   m_ov;
  iss_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m_ent[i].busy) c++;
    return c;
  endfunction

  // Reference behaviour for one clock edge, evaluated on the pre-edge state and inputs.
  task automatic model_step();
    ent_t nxt[DEPTH];
    int   sel = -1;
    int   fr = -1;
    int   cnt;
    iss_t e;
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) m_ent[i].busy = 0;
      m_ov = 0;
      return;
    end
    nxt = m_ent;
    cnt = m_count();
    for (int i = 0; i < DEPTH; i++) begin
      if (sel < 0 && m_ent[i].busy && m_ent[i].av && m_ent[i].bv) sel = i;
      if (fr < 0 && !m_ent[i].busy) fr = i;
      if (m_ent[i].busy && cdb_valid) begin
        if (!m_ent[i].av && m_ent[i].ao == cdb_rob_idx) begin nxt[i].av = 1; nxt[i].a = cdb_value; end
        if (!m_ent[i].bv && m_ent[i].bo == cdb_rob_idx) begin nxt[i].bv = 1; nxt[i].b = cdb_value; end
      end
    end
    if (sel >= 0 && (!m_ov || alu_ready)) begin
      nxt[sel].busy = 0;
      e.rob = m_ent[sel].rob; e.opc = m_ent[sel].opc; e.a = m_ent[sel].a;
      e.b = m_ent[sel].b; e.imm = m_ent[sel].imm;
      exp_q.push_back(e);
      m_ov = 1;
    end else if (alu_ready && m_ov) begin
      m_ov = 0;
    end
    if (in_instr_valid && cnt < DEPTH) begin
      nxt[fr].busy = 1; nxt[fr].rob = in_rob_idx; nxt[fr].opc = in_opcode; nxt[fr].imm = in_i;
      nxt[fr].ao = in_a_owner; nxt[fr].bo = in_b_owner;
      if (!in_a_valid && cdb_valid && cdb_rob_idx == in_a_owner) begin nxt[fr].av = 1; nxt[fr].a = cdb_value; end
      else begin nxt[fr].av = in_a_valid; nxt[fr].a = in_a_value; end
      if (!in_b_valid && cdb_valid && cdb_rob_idx == in_b_owner) begin nxt[fr].bv = 1; nxt[fr].b = cdb_value; end
      else begin nxt[fr].bv = in_b_valid; nxt[fr].b = in_b_value; end
    end
    m_ent = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("count", count, m_count());
    chk("full", full, (m_count() == DEPTH));
    chk("out_valid", out_valid, m_ov);
  endtask

  task automatic dispatch(input logic [3:0] rob, input logic [3:0] opc, input logic [7:0] imm,
                          input logic av, input logic [15:0] a, input logic [3:0] ao,
                          input logic bv, input logic [15:0] b, input logic [3:0] bo);
    in_instr_valid = 1; in_rob_idx = rob; in_opcode = opc; in_i = imm;
    in_a_valid = av; in_a_value = a; in_a_owner = ao;
    in_b_valid = bv; in_b_value = b; in_b_owner = bo;
  endtask

  task automatic idle();
    in_instr_valid = 0; cdb_valid = 0; flush = 0; reset = 0;
  endtask

  // Monitor: pops an expected issue whenever a new transaction appears on out_*.
  initial begin
    bit   last_ov = 0;
    bit   last_ar = 0;
    iss_t cur;
    cur = '{rob: 0, opc: 0, a: 0, b: 0, imm: 0};
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (!last_ov || last_ar) begin
          if (exp_q.size() == 0) chk("scoreboard_nonempty", 0, 1);
          else begin
            cur = exp_q.pop_front();
            $display("issue rob=%0d opc=%0d a=%h b=%h i=%h", out_rob_idx, out_opcode, out_a, out_b, out_i);
          end
        end
        chk("out_rob_idx", out_rob_idx, cur.rob);
        chk("out_opcode", out_opcode, cur.opc);
        chk("out_a", out_a, cur.a);
        chk("out_b", out_b, cur.b);
        chk("out_i", out_i, cur.imm);
      end
      last_ov = (out_valid === 1'b1);
      last_ar = alu_ready;
    end
  end

  initial begin
    reset = 1; flush = 0; in_instr_valid = 0; cdb_valid = 0; alu_ready = 1;
    in_rob_idx = 0; in_opcode = 0; in_i = 0; in_a_valid = 0; in_a_value = 0; in_a_owner = 0;
    in_b_valid = 0; in_b_value = 0; in_b_owner = 0; cdb_rob_idx = 0; cdb_value = 0;
    for (int i = 0; i < DEPTH; i++) m_ent[i].busy = 0;
    m_ov = 0;
    step(); step();
    chk("reset_count", count, 0);
    chk("reset_full", full, 0);
    idle();

    // Both operands ready: issue one edge after dispatch.
    dispatch(3, 0, 8'h11, 1, 16'd5, 0, 1, 16'd7, 0);
    step(); idle();
    step();
    chk("lat_out_valid", out_valid, 1);
    step();
    chk("lat_count_back", count, 0);

    // Wakeup from the result bus.
    dispatch(2, 1, 8'h22, 0, 16'h0, 9, 1, 16'h55, 0);
    step(); idle();
    repeat (3) step();
    cdb_valid = 1; cdb_rob_idx = 9; cdb_value = 16'h1234;
    step(); idle();
    step(); step();

    // Fill to DEPTH, drop the fifth dispatch, then drain one.
    for (int k = 0; k < DEPTH; k++) begin
      dispatch(4'(4 + k), 2, 8'(k), 0, 16'h0, 4'(10 + k), 1, 16'(k), 0);
      step();
    end
    chk("full_at_depth", full, 1);
    dispatch(15, 3, 8'hFF, 1, 16'h1, 0, 1, 16'h2, 0);
    step();
    chk("fifth_dropped_count", count, 4);
    idle();
    cdb_valid = 1; cdb_rob_idx = 10; cdb_value = 16'hA0A0;
    step(); idle();
    step(); step();
    chk("full_after_issue", full, 0);
    flush = 1; step(); idle();

    // Back-pressure with two ready entries, then back-to-back issue.
    alu_ready = 0;
    dispatch(6, 4, 8'h66, 1, 16'h6, 0, 1, 16'h66, 0); step();
    dispatch(7, 5, 8'h77, 1, 16'h7, 0, 1, 16'h77, 0); step();
    idle();
    repeat (4) step();
    chk("hold_count", count, 1);
    alu_ready = 1;
    repeat (3) step();

    // Dispatch-time bypass from the result bus.
    dispatch(8, 6, 8'h88, 0, 16'h0, 4, 1, 16'h9, 0);
    cdb_valid = 1; cdb_rob_idx = 4; cdb_value = 16'hBEEF;
    step(); idle();
    step(); step();

    // Flush, then reset, with three busy entries and a held issue.
    for (int pass = 0; pass < 2; pass++) begin
      alu_ready = 0;
      dispatch(1, 7, 8'h01, 1, 16'h1, 0, 1, 16'h2, 0); step();
      for (int k = 0; k < 3; k++) begin
        dispatch(4'(11 + k), 7, 8'h02, 0, 16'h0, 14, 1, 16'h3, 0); step();
      end
      chk("pre_kill_count", count, 3);
      dispatch(12, 8, 8'h03, 1, 16'h4, 0, 1, 16'h5, 0);
      if (pass == 0) flush = 1; else reset = 1;
      step(); idle();
      chk("kill_count", count, 0);
      chk("kill_out_valid", out_valid, 0);
      alu_ready = 1;
      step();
    end

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      in_instr_valid = 1'($urandom_range(0, 1));
      in_rob_idx = 4'($urandom); in_opcode = 4'($urandom); in_i = 8'($urandom);
      in_a_valid = 1'($urandom_range(0, 1)); in_a_value = 16'($urandom); in_a_owner = 4'($urandom_range(0, 3));
      in_b_valid = 1'($urandom_range(0, 1)); in_b_value = 16'($urandom); in_b_owner = 4'($urandom_range(0, 3));
      cdb_valid = 1'($urandom_range(0, 1)); cdb_rob_idx = 4'($urandom_range(0, 3)); cdb_value = 16'($urandom);
      alu_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    idle(); alu_ready = 1;
    repeat (10) step();
    @(negedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fxu_reservation_station.md
FXU_RESERVATION_STATION -- requirements
Module: fxu_reservation_station

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries (2..8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-004 SHALL have ports in_instr_valid 1, in_rob_idx 4, in_opcode 4, in_i 8, all inputs; these form the dispatch request from the instruction buffer.
REQ-005 SHALL have ports in_a_valid 1, in_a_value 16, in_a_owner 4, in_b_valid 1, in_b_value 16, in_b_owner 4, all inputs; these are the operand tag/value pairs.
REQ-006 SHALL have port full  output  1  no free entry; dispatcher withholds dispatch while high.
REQ-007 SHALL have ports cdb_valid 1, cdb_rob_idx 4, cdb_value 16, all inputs; this is the result broadcast.
REQ-008 SHALL have port flush  input  1  discards all entries and issue register.
REQ-009 SHALL have ports out_valid 1, out_rob_idx 4, out_opcode 4, out_a 16, out_b 16, out_i 8, all outputs; this is the issue register to the FXU.
REQ-010 SHALL have port alu_ready  input  1  FXU accepts issue register this cycle.
REQ-011 SHALL have port count  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-012 SHALL hold per entry: busy, rob_idx, opcode, imm, a_valid/a_value/a_owner, b_valid/b_value/b_owner.
REQ-013 SHALL drive full = (count == DEPTH), decoded from registered occupancy only, with no same-cycle credit for an issuing entry.
REQ-014 SHALL accept a dispatch when in_instr_valid & ~full & ~flush, writing the lowest-index free entry at the posedge.
REQ-015 SHALL silently drop in_instr_valid while full; occupancy and entries stay unchanged.
REQ-016 SHALL apply dispatch bypass: when an incoming operand is not valid and cdb_valid & cdb_rob_idx == owner in the same cycle, it SHALL store value = cdb_value and valid = 1.
REQ-017 SHALL apply wakeup: each busy entry operand with valid=0 and owner == cdb_rob_idx while cdb_valid SHALL capture cdb_value and set valid at the posedge; a and b wake independently, and both wake if both owners match.
REQ-018 SHALL treat an entry as ready when busy & a_valid & b_valid, using registered state only; a wakeup takes effect for selection the following cycle.
REQ-019 SHALL select, among ready entries, the lowest index.
REQ-020 SHALL load the issue register when a ready entry exists and (out_valid==0 or alu_ready==1); the selected entry SHALL be freed on the same edge.
REQ-021 SHALL clear out_valid when alu_ready & out_valid and no ready entry exists.
REQ-022 SHALL hold out_* stable while out_valid & ~alu_ready.
REQ-023 SHALL allow a dispatch and an issue on the same edge; the count delta is +1-1 = 0, and the freed index is not reusable until the next cycle.
REQ-024 SHALL give a dispatch with both operands valid at edge N an out_valid at edge N+1 (minimum 2-edge latency from presentation).
REQ-025 SHALL make count = popcount(busy), with arithmetic exact in the count width and no wrap.
REQ-026 SHALL, on flush, clear all busy bits and out_valid at the posedge; flush has priority over dispatch, wakeup and issue.
REQ-027 SHALL keep the data fields of free entries and of out_* when invalid don't-care, but they SHALL never be X-propagated into valid/busy/full.

Reset
REQ-028 SHALL, on reset, clear all busy bits and out_valid; count=0 and full=0 after the edge.
REQ-029 SHALL give reset priority over flush, dispatch, wakeup and alu_ready; reset mid-operation discards all entries and the pending issue.
REQ-030 SHALL leave data registers unreset.

Verification
REQ-031 SHALL be verified by: dispatch rob_idx=3, opcode=0, a=5 valid, b=7 valid, alu_ready=1 -> out_valid one edge later with out_a=5, out_b=7, out_rob_idx=3; count returns to 0.
REQ-032 SHALL be verified by: dispatch rob_idx=2 with a owner=9 invalid; 3 cycles later cdb_valid, cdb_rob_idx=9, cdb_value=0x1234 -> entry issues next edge with out_a=0x1234.
REQ-033 SHALL be verified by: DEPTH=4, four non-ready dispatches -> full=1, count=4; fifth dispatch dropped; one wakeup+issue -> full=0 the following cycle.
REQ-034 SHALL be verified by: alu_ready=0 with two ready entries -> out_* constant, count=1 held; alu_ready=1 -> second entry loaded same edge, back-to-back issue.
REQ-035 SHALL be verified by: dispatch with owner=4 in the same cycle as cdb_rob_idx=4, value=0xBEEF -> entry ready immediately, issues with out_a=0xBEEF.
REQ-036 SHALL be verified by: flush (then reset) with 3 busy entries and out_valid=1 -> count=0, full=0, out_valid=0 next edge; a simultaneous dispatch is ignored.
